// File: rtl/obi_sram_bridge.sv
// -----------------------------------------------------------------------------
// obi_sram_bridge
//
// Slave-side bridge from one OBI port to a single-port SRAM wrapper. OBI byte
// addresses become SRAM word indices, and every granted transaction gets one
// registered response one cycle after its grant. The bridge also sequences
// the SRAM power-gate and retention controls for the power manager, and it
// withholds grants while the macro is not fully powered.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   obi_*                  OBI slave port (req/gnt, addr/we/be/wdata, rvalid/rdata)
//   pm_off_i, pm_ret_i     power manager: power-down request, retention request
//   pm_off_ack_o           high while the SRAM is fully gated
//   mem_req_o .. mem_be_o  SRAM request and payload
//   mem_rdata_i            SRAM read data, valid one cycle after the request
//   mem_pwrgate_no         power-gate control, low = gated
//   mem_pwrgate_ack_ni     power-gate acknowledge from the macro
//   mem_set_retentive_no   retention control, low = retentive
// -----------------------------------------------------------------------------
module obi_sram_bridge #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // OBI slave
  input  logic                 obi_req_i,
  output logic                 obi_gnt_o,
  input  logic [31:0]          obi_addr_i,
  input  logic                 obi_we_i,
  input  logic [3:0]           obi_be_i,
  input  logic [31:0]          obi_wdata_i,
  output logic                 obi_rvalid_o,
  output logic [31:0]          obi_rdata_o,
  // power manager
  input  logic                 pm_off_i,
  input  logic                 pm_ret_i,
  output logic                 pm_off_ack_o,
  // SRAM
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  output logic [3:0]           mem_be_o,
  input  logic [31:0]          mem_rdata_i,
  output logic                 mem_pwrgate_no,
  input  logic                 mem_pwrgate_ack_ni,
  output logic                 mem_set_retentive_no
);

  typedef enum logic [2:0] {
    S_ON,
    S_DRAIN,
    S_GATING,
    S_OFF,
    S_WAKING
  } state_e;

  state_e state_q, state_d;
  logic   rvalid_q;
  logic   rsp_we_q;
  logic   ret_n_q;

  // ---------------------------------------------------------------------------
  // Request path: grants only in ON, and a power-down request wins over a
  // simultaneous bus request. The request then stays pending on the bus.
  // ---------------------------------------------------------------------------
  assign obi_gnt_o   = (state_q == S_ON) && obi_req_i && !pm_off_i;
  assign mem_req_o   = obi_gnt_o;
  assign mem_we_o    = obi_we_i;
  assign mem_addr_o  = obi_addr_i[AddrWidth+1:2];
  assign mem_wdata_o = obi_wdata_i;
  assign mem_be_o    = obi_be_i;

  // The byte offset and the address bits above the SRAM range are ignored.
  logic unused_addr;
  assign unused_addr = ^{obi_addr_i[31:AddrWidth+2], obi_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: assign a default to every always_comb output before any branch.
    // A path that leaves a signal unassigned infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_ON:     if (pm_off_i) state_d = S_DRAIN;
      S_DRAIN:  state_d = S_GATING;
      // An aborted power-down takes priority over a late acknowledge. WAKING
      // re-powers the macro in either case.
      S_GATING: begin
        if (!pm_off_i)                state_d = S_WAKING;
        else if (!mem_pwrgate_ack_ni) state_d = S_OFF;
      end
      S_OFF:    if (!pm_off_i) state_d = S_WAKING;
      S_WAKING: if (mem_pwrgate_ack_ni) state_d = S_ON;
      default:  state_d = S_ON;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: use non-blocking assignments for all flop state. This keeps every
    // register sampling pre-edge values, whatever order the blocks run in.
    if (!rst_ni) begin
      state_q  <= S_ON;
      rvalid_q <= 1'b0;
      rsp_we_q <= 1'b0;
      ret_n_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      rvalid_q <= obi_gnt_o;
      rsp_we_q <= obi_gnt_o && obi_we_i;
      // Retention is registered against the next state so the macro control
      // comes straight from a flop. It is low exactly while the FSM sits in
      // GATING/OFF with retention requested.
      ret_n_q  <= !(pm_ret_i && (state_d == S_GATING || state_d == S_OFF));
    end
  end

  // Read data arrives from the SRAM in the response cycle. It is forwarded
  // for reads and forced to zero otherwise.
  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = (rvalid_q && !rsp_we_q) ? mem_rdata_i : 32'h0;

  // ---------------------------------------------------------------------------
  // Power controls, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign mem_pwrgate_no       = !(state_q == S_GATING || state_q == S_OFF);
  assign pm_off_ack_o         = (state_q == S_OFF);
  assign mem_set_retentive_no = ret_n_q;

endmodule

// File: tb/tb_obi_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_obi_sram_bridge
//
// Directed bench for obi_sram_bridge. It contains a behavioural SRAM with
// byte enables and a one-cycle read latency. The power-gate acknowledge is
// driven by hand from the stimulus.
//
// Each grant pushes its expected rdata, together with the grant cycle, into a
// scoreboard queue. A separate monitor pops one entry on every rvalid and
// checks both the data and the one-cycle response latency.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_obi_sram_bridge;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          obi_req = 1'b0, obi_we = 1'b0;
  logic [31:0]   obi_addr = '0, obi_wdata = '0;
  logic [3:0]    obi_be = '0;
  logic          obi_gnt, obi_rvalid;
  logic [31:0]   obi_rdata;
  logic          pm_off = 1'b0, pm_ret = 1'b0, pm_off_ack;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          mem_pwrgate_n, mem_pwrgate_ack_n = 1'b1, mem_ret_n;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  obi_sram_bridge dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .obi_req_i            (obi_req),
    .obi_gnt_o            (obi_gnt),
    .obi_addr_i           (obi_addr),
    .obi_we_i             (obi_we),
    .obi_be_i             (obi_be),
    .obi_wdata_i          (obi_wdata),
    .obi_rvalid_o         (obi_rvalid),
    .obi_rdata_o          (obi_rdata),
    .pm_off_i             (pm_off),
    .pm_ret_i             (pm_ret),
    .pm_off_ack_o         (pm_off_ack),
    .mem_req_o            (mem_req),
    .mem_we_o             (mem_we),
    .mem_addr_o           (mem_addr),
    .mem_wdata_o          (mem_wdata),
    .mem_be_o             (mem_be),
    .mem_rdata_i          (mem_rdata),
    .mem_pwrgate_no       (mem_pwrgate_n),
    .mem_pwrgate_ack_ni   (mem_pwrgate_ack_n),
    .mem_set_retentive_no (mem_ret_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-enabled write, read data one cycle after request.
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= sram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst_n && obi_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", obi_rdata, e.data);
        check("rsp_latency", cyc, e.cyc + 1);
      end
    end
  end

  // Present a request and wait (bounded) for its grant. On grant, the task
  // checks the wait count and SRAM address and queues the expected response.
  // With hold set, req stays high so the next call continues back-to-back.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic [31:0] exp_maddr, input int exp_wait,
                      input bit hold, input string name);
    int waited = 0;
    obi_req   = 1'b1;
    obi_we    = we;
    obi_addr  = addr;
    obi_be    = be;
    obi_wdata = wdata;
    @(negedge clk);
    while (!obi_gnt && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (!obi_gnt) begin
      check({name, "_gnt_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_gnt_wait"}, waited, exp_wait);
      check({name, "_mem_addr"}, 32'(mem_addr), exp_maddr);
      if (we) check({name, "_mem_be"}, 32'(mem_be), 32'(be));
      sb.push_back('{data: exp_rdata, cyc: cyc});
    end
    @(posedge clk); #1;
    if (!hold) obi_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset values
    check("rst_rvalid", 32'(obi_rvalid), 32'd0);
    check("rst_rdata", obi_rdata, 32'd0);
    check("rst_off_ack", 32'(pm_off_ack), 32'd0);
    check("rst_pwrgate_n", 32'(mem_pwrgate_n), 32'd1);
    check("rst_ret_n", 32'(mem_ret_n), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_gnt", 32'(obi_gnt), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Write then read
    xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 32'd4, 0, 1'b0, "wr_full");
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 32'd4, 0, 1'b0, "rd_full");

    // Byte-enable write, then read; then an aliased address (high bits ignored)
    xfer(1'b1, 32'h10, 4'h1, 32'h000000AA, 32'h0, 32'd4, 0, 1'b0, "wr_byte");
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 32'd4, 0, 1'b0, "rd_byte");
    xfer(1'b0, 32'hFFFF_F013, 4'hF, 32'h0, 32'hDEADBEAA, 32'd4, 0, 1'b0, "rd_alias");

    // Back-to-back writes and reads of words 8..11
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'h20 + 32'(4*i), 4'hF, 32'h11110000 + 32'(i), 32'h0,
           32'(8 + i), 0, (i < 3), "b2b_wr");
    for (int i = 0; i < 4; i++)
      xfer(1'b0, 32'h20 + 32'(4*i), 4'hF, 32'h0, 32'h11110000 + 32'(i),
           32'(8 + i), 0, (i < 3), "b2b_rd");
    step();

    // Power-down during traffic, with retention
    pm_ret = 1'b1;
    xfer(1'b0, 32'h20, 4'hF, 32'h0, 32'h11110000, 32'd8, 0, 1'b1, "pd_prev");
    obi_addr = 32'h24;
    pm_off   = 1'b1;
    @(negedge clk);                        // ON, pm_off wins
    check("pd_no_gnt", 32'(obi_gnt), 32'd0);
    check("pd_on_pwrgate_n", 32'(mem_pwrgate_n), 32'd1);
    step(); @(negedge clk);                // DRAIN
    check("pd_drain_gnt", 32'(obi_gnt), 32'd0);
    check("pd_drain_mem_req", 32'(mem_req), 32'd0);
    check("pd_drain_pwrgate_n", 32'(mem_pwrgate_n), 32'd1);
    step(); @(negedge clk);                // GATING
    check("pd_gating_pwrgate_n", 32'(mem_pwrgate_n), 32'd0);
    check("pd_gating_ret_n", 32'(mem_ret_n), 32'd0);
    check("pd_gating_off_ack", 32'(pm_off_ack), 32'd0);
    repeat (3) step();
    mem_pwrgate_ack_n = 1'b0;              // ack after 3 GATING cycles
    @(negedge clk);
    check("pd_ack_cycle_off_ack", 32'(pm_off_ack), 32'd0);
    step(); @(negedge clk);                // OFF
    check("pd_off_ack", 32'(pm_off_ack), 32'd1);
    check("pd_off_pwrgate_n", 32'(mem_pwrgate_n), 32'd0);
    check("pd_off_ret_n", 32'(mem_ret_n), 32'd0);
    check("pd_off_gnt", 32'(obi_gnt), 32'd0);
    repeat (2) step();
    pm_off = 1'b0;
    @(negedge clk);                        // still OFF this cycle
    check("wk_off_ack_hold", 32'(pm_off_ack), 32'd1);
    step(); @(negedge clk);                // WAKING
    check("wk_pwrgate_n", 32'(mem_pwrgate_n), 32'd1);
    check("wk_off_ack", 32'(pm_off_ack), 32'd0);
    check("wk_ret_n", 32'(mem_ret_n), 32'd1);
    check("wk_gnt", 32'(obi_gnt), 32'd0);
    step();
    mem_pwrgate_ack_n = 1'b1;
    @(negedge clk);
    check("wk_ack_cycle_gnt", 32'(obi_gnt), 32'd0);
    step();                                // ON: pending read granted at once
    xfer(1'b0, 32'h24, 4'hF, 32'h0, 32'h11110001, 32'd9, 0, 1'b0, "pd_pending");
    step();

    // Retention with wake abort in GATING
    pm_off = 1'b1;
    step();                                // DRAIN
    step(); @(negedge clk);                // GATING
    check("ab_gating_ret_n", 32'(mem_ret_n), 32'd0);
    check("ab_gating_pwrgate_n", 32'(mem_pwrgate_n), 32'd0);
    step();
    pm_off = 1'b0;                         // abort before ack
    @(negedge clk);
    check("ab_gating_off_ack", 32'(pm_off_ack), 32'd0);
    step(); @(negedge clk);                // WAKING
    check("ab_wk_off_ack", 32'(pm_off_ack), 32'd0);
    check("ab_wk_pwrgate_n", 32'(mem_pwrgate_n), 32'd1);
    check("ab_wk_ret_n", 32'(mem_ret_n), 32'd1);
    step();                                // ON
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 32'd4, 0, 1'b0, "ab_rd");
    step();

    // Async reset while OFF
    pm_ret = 1'b0;
    pm_off = 1'b1;
    step();                                // DRAIN
    step();                                // GATING
    mem_pwrgate_ack_n = 1'b0;
    @(negedge clk);
    check("rs_gating_ret_n", 32'(mem_ret_n), 32'd1);
    step(); @(negedge clk);                // OFF
    check("rs_off_ack", 32'(pm_off_ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_pwrgate_n", 32'(mem_pwrgate_n), 32'd1);
    check("rs_off_ack_clr", 32'(pm_off_ack), 32'd0);
    check("rs_rvalid", 32'(obi_rvalid), 32'd0);
    pm_off = 1'b0;
    mem_pwrgate_ack_n = 1'b1;
    step();
    rst_n = 1'b1;
    xfer(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEAA, 32'd4, 0, 1'b0, "rs_rd");

    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
